// File: rtl/axil_arbiter.sv
// Two-requester round-robin arbiter onto a single AXI-lite master port.
// One transaction in flight at a time; completion is a one-cycle pulse to the owner.
module axil_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_n,
  input  logic [1:0]                i_Req_Valid,
  input  logic [1:0]                i_Req_Write,
  input  logic [2*ADDR_WIDTH-1:0]   i_Req_Addr,
  input  logic [2*DATA_WIDTH-1:0]   i_Req_Wdata,
  input  logic [2*DATA_WIDTH/8-1:0] i_Req_Wstrb,
  output logic [1:0]                o_Req_Done,
  output logic [DATA_WIDTH-1:0]     o_Rdata,
  output logic [1:0]                o_Resp,
  output logic                      o_Grant,
  output logic [ADDR_WIDTH-1:0]     m_axil_araddr,
  output logic                      m_axil_arvalid,
  input  logic                      m_axil_arready,
  input  logic [DATA_WIDTH-1:0]     m_axil_rdata,
  input  logic [1:0]                m_axil_rresp,
  input  logic                      m_axil_rvalid,
  output logic                      m_axil_rready,
  output logic [ADDR_WIDTH-1:0]     m_axil_awaddr,
  output logic                      m_axil_awvalid,
  input  logic                      m_axil_awready,
  output logic [DATA_WIDTH-1:0]     m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axil_wstrb,
  output logic                      m_axil_wvalid,
  input  logic                      m_axil_wready,
  input  logic [1:0]                m_axil_bresp,
  input  logic                      m_axil_bvalid,
  output logic                      m_axil_bready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, AR, R, AW, B, DONE} state_t;

  state_t                  state;
  logic                    prefer;
  logic                    owner;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [STRB_WIDTH-1:0]   wstrb;
  logic                    arvalid, rready, awvalid, wvalid, bready;
  logic [1:0]              done;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              resp;

  logic                    sel;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   aligned;
  logic                    aw_ok, w_ok;

  always_comb begin
    // Contention goes to whoever was not granted last; a lone request wins outright.
    sel       = (i_Req_Valid == 2'b11) ? prefer : i_Req_Valid[1];
    req_write = i_Req_Write[sel];
    aligned   = addr & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    aw_ok     = !awvalid || m_axil_awready;
    w_ok      = !wvalid  || m_axil_wready;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state   <= IDLE;
      prefer  <= 1'b0;
      owner   <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      done    <= '0;
      rdata   <= '0;
      resp    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|i_Req_Valid) begin
            owner  <= sel;
            prefer <= ~sel;
            addr   <= sel ? i_Req_Addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : i_Req_Addr[ADDR_WIDTH-1:0];
            wdata  <= sel ? i_Req_Wdata[2*DATA_WIDTH-1:DATA_WIDTH] : i_Req_Wdata[DATA_WIDTH-1:0];
            wstrb  <= sel ? i_Req_Wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : i_Req_Wstrb[STRB_WIDTH-1:0];
            if (req_write) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= AW;
            end else begin
              arvalid <= 1'b1;
              state   <= AR;
            end
          end
        end
        AR: begin
          if (m_axil_arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (m_axil_rvalid) begin
            rready <= 1'b0;
            rdata  <= m_axil_rdata;
            resp   <= m_axil_rresp;
            done   <= owner ? 2'b10 : 2'b01;
            state  <= DONE;
          end
        end
        AW: begin
          // Address and data channels retire independently, possibly on the same edge.
          if (m_axil_awready) awvalid <= 1'b0;
          if (m_axil_wready)  wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready <= 1'b1;
            state  <= B;
          end
        end
        B: begin
          if (m_axil_bvalid) begin
            bready <= 1'b0;
            rdata  <= '0;
            resp   <= m_axil_bresp;
            done   <= owner ? 2'b10 : 2'b01;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          rdata <= '0;
          resp  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_Req_Done     = done;
  assign o_Rdata        = rdata;
  assign o_Resp         = resp;
  assign o_Grant        = owner;
  assign m_axil_araddr  = arvalid ? aligned : '0;
  assign m_axil_arvalid = arvalid;
  assign m_axil_rready  = rready;
  assign m_axil_awaddr  = awvalid ? aligned : '0;
  assign m_axil_awvalid = awvalid;
  assign m_axil_wdata   = wvalid ? wdata : '0;
  assign m_axil_wstrb   = wvalid ? wstrb : '0;
  assign m_axil_wvalid  = wvalid;
  assign m_axil_bready  = bready;

endmodule

// File: tb/tb_axil_arbiter.sv
// Directed bench for axil_arbiter: slave handshakes are driven cycle by cycle,
// outputs are sampled on the falling edge against hand-computed values.
module tb_axil_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [7:0]      req_wstrb;
  logic [1:0]      req_done;
  logic [DW-1:0]   rdata_o;
  logic [1:0]      resp_o;
  logic            grant;
  logic [AW-1:0]   araddr, awaddr;
  logic            arvalid, arready, rvalid, rready, awvalid, awready;
  logic            wvalid, wready, bvalid, bready;
  logic [DW-1:0]   rdata, wdata;
  logic [1:0]      rresp, bresp;
  logic [3:0]      wstrb;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  axil_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n),
    .i_Req_Valid(req_valid), .i_Req_Write(req_write), .i_Req_Addr(req_addr),
    .i_Req_Wdata(req_wdata), .i_Req_Wstrb(req_wstrb),
    .o_Req_Done(req_done), .o_Rdata(rdata_o), .o_Resp(resp_o), .o_Grant(grant),
    .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready),
    .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " arvalid"}, arvalid, 1'b0);
    check({tag, " rready"},  rready,  1'b0);
    check({tag, " awvalid"}, awvalid, 1'b0);
    check({tag, " wvalid"},  wvalid,  1'b0);
    check({tag, " bready"},  bready,  1'b0);
    check({tag, " done"},    req_done, 2'b00);
    check({tag, " rdata"},   rdata_o, 32'h0);
    check({tag, " resp"},    resp_o,  2'b00);
    check({tag, " grant"},   grant,   1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait read from requester 0
    req_valid = 2'b01; req_write = 2'b00; req_addr[15:0] = 16'h0106;
    arready = 1; rvalid = 1; rdata = 32'hDEADBEEF; rresp = 2'b00;
    tick();
    req_valid = 2'b00;
    check("rd arvalid", arvalid, 1'b1);
    check("rd araddr", araddr, 16'h0104);
    check("rd grant", grant, 1'b0);
    check("rd done early", req_done, 2'b00);
    tick();
    check("rd arvalid drop", arvalid, 1'b0);
    check("rd araddr zero", araddr, 16'h0000);
    check("rd rready", rready, 1'b1);
    tick();
    check("rd done", req_done, 2'b01);
    check("rd rdata", rdata_o, 32'hDEADBEEF);
    check("rd resp", resp_o, 2'b00);
    tick();
    check("rd done pulse", req_done, 2'b00);
    arready = 0; rvalid = 0;

    // Write from requester 1, awready one cycle before wready, SLVERR
    req_valid = 2'b10; req_write = 2'b10; req_addr[31:16] = 16'h0203;
    req_wdata[63:32] = 32'h12345678; req_wstrb[7:4] = 4'b0011;
    tick();
    req_valid = 2'b00;
    check("wr awvalid", awvalid, 1'b1);
    check("wr wvalid", wvalid, 1'b1);
    check("wr awaddr", awaddr, 16'h0200);
    check("wr wdata", wdata, 32'h12345678);
    check("wr wstrb", wstrb, 4'b0011);
    check("wr grant", grant, 1'b1);
    awready = 1;
    tick();
    check("wr awvalid drop", awvalid, 1'b0);
    check("wr awaddr zero", awaddr, 16'h0000);
    check("wr wvalid held", wvalid, 1'b1);
    check("wr bready early", bready, 1'b0);
    awready = 0; wready = 1;
    tick();
    check("wr wvalid drop", wvalid, 1'b0);
    check("wr bready", bready, 1'b1);
    wready = 0; bvalid = 1; bresp = 2'b10;
    tick();
    bvalid = 0;
    check("wr done", req_done, 2'b10);
    check("wr resp", resp_o, 2'b10);
    check("wr rdata", rdata_o, 32'h0);
    check("wr bready drop", bready, 1'b0);
    tick();
    check("wr done pulse", req_done, 2'b00);

    // Both requesters held valid after a fresh reset: grants alternate from 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 2'b11; req_write = 2'b00; req_addr = {16'h2000, 16'h1000};
    arready = 1; rvalid = 1; rdata = 32'h0000_0A5A;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr%0d grant", i), grant, (i % 2 == 1));
      check($sformatf("rr%0d araddr", i), araddr, (i % 2 == 1) ? 16'h2000 : 16'h1000);
      tick();
      tick();
      check($sformatf("rr%0d done", i), req_done, (i % 2 == 1) ? 2'b10 : 2'b01);
      tick();
      check($sformatf("rr%0d done pulse", i), req_done, 2'b00);
    end
    req_valid = 2'b00; arready = 0; rvalid = 0;

    // arready stalls five cycles while requester 1 waits
    req_valid = 2'b01; req_addr = {16'h0402, 16'h0306};
    tick();
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d arvalid", i), arvalid, 1'b1);
      check($sformatf("stall%0d araddr", i), araddr, 16'h0304);
      check($sformatf("stall%0d grant", i), grant, 1'b0);
      req_valid = 2'b10;
    end
    arready = 1;
    tick();
    arready = 0;
    check("stall rready", rready, 1'b1);
    rvalid = 1; rdata = 32'hCAFEF00D;
    tick();
    rvalid = 0;
    check("stall done", req_done, 2'b01);
    check("stall rdata", rdata_o, 32'hCAFEF00D);
    tick();
    check("stall idle arvalid", arvalid, 1'b0);
    tick();
    req_valid = 2'b00;
    check("stall req1 grant", grant, 1'b1);
    check("stall req1 araddr", araddr, 16'h0400);
    arready = 1; rvalid = 1; rdata = 32'h0000_1111;
    tick();
    tick();
    check("stall req1 done", req_done, 2'b10);
    arready = 0; rvalid = 0;
    tick();

    // Reset while waiting in R; response after release must be ignored
    req_valid = 2'b10; req_addr[31:16] = 16'h0508; arready = 1;
    tick();
    req_valid = 2'b00;
    tick();
    arready = 0;
    check("rst pre rready", rready, 1'b1);
    check("rst pre grant", grant, 1'b1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst async");
    @(negedge clk);
    rst_n = 1'b1;
    rvalid = 1; rdata = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst late%0d done", i), req_done, 2'b00);
      check($sformatf("rst late%0d rdata", i), rdata_o, 32'h0);
    end
    rvalid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axil_arbiter.md
AXIL_ARBITER -- requirements
Module: axil_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, byte-address width of requests and of the AXI-lite master port.
REQ-002 Parameter DATA_WIDTH, default 32, data width; strobe width is DATA_WIDTH/8.
REQ-003 i_Clock  in  1  the single clock; all state changes on rising edge.
REQ-004 i_Reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_Req_Valid  in  2  per-requester request; bit 0 instruction fetch, bit 1 load/store.
REQ-006 i_Req_Write  in  2  per-requester direction, 1=write.
REQ-007 i_Req_Addr  in  2*ADDR_WIDTH  per-requester byte address; requester n in slice n.
REQ-008 i_Req_Wdata  in  2*DATA_WIDTH  per-requester write data.
REQ-009 i_Req_Wstrb  in  2*DATA_WIDTH/8  per-requester byte strobes.
REQ-010 o_Req_Done  out  2  one-cycle completion pulse to the owning requester.
REQ-011 o_Rdata  out  DATA_WIDTH  read data, valid while o_Req_Done nonzero; 0 for writes.
REQ-012 o_Resp  out  2  captured RRESP/BRESP, valid while o_Req_Done nonzero.
REQ-013 o_Grant  out  1  index of current/last owner.
REQ-014 m_axil_araddr / arvalid  out  ADDR_WIDTH / 1;  m_axil_arready  in  1.
REQ-015 m_axil_rdata / rresp / rvalid  in  DATA_WIDTH / 2 / 1;  m_axil_rready  out  1.
REQ-016 m_axil_awaddr / awvalid  out  ADDR_WIDTH / 1;  m_axil_awready  in  1.
REQ-017 m_axil_wdata / wstrb / wvalid  out  DATA_WIDTH / DATA_WIDTH/8 / 1;  m_axil_wready  in  1.
REQ-018 m_axil_bresp / bvalid  in  2 / 1;  m_axil_bready  out  1.

Function
REQ-019 States SHALL be IDLE, AR, R, AW, B, DONE; exactly one transaction outstanding.
REQ-020 i_Req_Valid SHALL be sampled only in IDLE; a sampled request latches write, addr, wdata, wstrb, owner and moves to AR (read) or AW (write).
REQ-021 Arbitration SHALL be round-robin: one valid -> grant it; both valid -> grant the one not last granted; pointer after reset favours requester 0.
REQ-022 Forwarded araddr/awaddr SHALL be latched addr with bits [1:0] forced to 0; addresses SHALL be 0 when the channel valid is low.
REQ-023 AR: arvalid=1, address stable until arready; handshake -> R.
REQ-024 R: rready=1; on rvalid capture rdata/rresp -> DONE.
REQ-025 AW: awvalid and wvalid both raised on entry, each dropped independently after its own handshake (same-cycle handshakes allowed); both done -> B.
REQ-026 B: bready=1; on bvalid capture bresp, o_Rdata=0 -> DONE.
REQ-027 DONE: o_Req_Done[owner]=1 for exactly one cycle, then IDLE; requester SHALL drop valid by the edge ending DONE, else it is re-sampled as a new request.
REQ-028 Minimum latency with zero-wait slave: 3 cycles from sampling edge to o_Req_Done; one IDLE cycle between transactions.
REQ-029 Requester valid dropped mid-transaction SHALL be ignored; transaction completes and Done still pulses.
REQ-030 Non-owner requests SHALL wait, never abort or preempt the current transaction.

Reset
REQ-031 Reset assertion SHALL immediately force IDLE, all AXI valid/ready outputs, o_Req_Done, o_Rdata, o_Resp and o_Grant to 0, regardless of state.
REQ-032 Transactions in flight at reset SHALL be abandoned with no Done; late slave responses after reset SHALL be ignored.

Verification
REQ-033 Read req0 addr 0x0106, zero-wait slave rdata 0xDEADBEEF -> araddr 0x0104 one cycle, o_Req_Done=2'b01, o_Rdata=0xDEADBEEF, o_Resp=0, 3 cycles after sampling.
REQ-034 Both requesters hold valid continuously after reset -> grants 0,1,0,1 in order, each Done pulse single-cycle.
REQ-035 Write req1 addr 0x0203, wdata 0x12345678, wstrb 4'b0011, awready 1 cycle before wready, bresp 2'b10 -> awaddr 0x0200, awvalid drops first, wvalid held, o_Req_Done=2'b10, o_Resp=2'b10, o_Rdata=0.
REQ-036 arready low for 5 cycles, req1 raised meanwhile -> araddr/arvalid stable, req1 granted only after req0 Done.
REQ-037 Reset asserted in R, rvalid arrives after release -> outputs 0 immediately, rvalid ignored, no Done.
